// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO and valid/ready drain.
// Detects framing errors (low stop bit) and flags dropped bytes as sticky overflow.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_pin,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = 7;
  localparam logic [CntW-1:0] Half   = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] BitMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   Full   = (PtrW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

  logic sync_q, rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rx_pin;
      rx_s   <= sync_q;
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, frame_err_d;

  // cnt_q holds the cycles remaining until the next bit sample.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          bit_d = 3'd0;
          // With no half-bit offset the start sample is this very cycle.
          if (Half == '0) begin
            state_d = StData;
            cnt_d   = BitMax;
          end else begin
            state_d = StStart;
            cnt_d   = Half - CntW'(1);
          end
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rx_s) begin
          state_d = StIdle;
        end else begin
          state_d = StData;
          cnt_d   = BitMax;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 3'd1;
          cnt_d          = BitMax;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rx_s) begin
          push    = 1'b1;
          state_d = StIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   count_q;
  logic            frame_err_q, overflow_q;
  logic            full, pop, push_ok;

  assign full    = (count_q == Full);
  assign pop     = data_valid && data_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      if (push && !push_ok) overflow_q <= 1'b1;
      if (push_ok) wr_q <= wr_q + PtrW'(1);
      if (pop) rd_q <= rd_q + PtrW'(1);
      if (push_ok && !pop) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end

  assign data_valid = (count_q != '0);
  assign data_out   = data_valid ? mem_q[rd_q] : 8'h00;
  assign level      = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (1 and 4 clocks per bit) driven with serial frames,
// every popped byte compared against a queue of expected bytes.
module tb_uart_rx_fifo;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx [2];
  logic       dr [2];
  logic [7:0] dout [2];
  logic       dv [2];
  logic [2:0] lvl [2];
  logic       ferr [2];
  logic       ovf [2];

  int         checks = 0;
  int         errors = 0;
  int         ferr_cnt [2];
  logic       ovf_m [2];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(Depth)) u_dut_c1 (
    .clk(clk), .reset(reset), .rx_pin(rx[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .data_ready(dr[0]), .level(lvl[0]), .frame_err(ferr[0]), .overflow(ovf[0])
  );

  uart_rx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(Depth)) u_dut_c4 (
    .clk(clk), .reset(reset), .rx_pin(rx[1]), .data_out(dout[1]), .data_valid(dv[1]),
    .data_ready(dr[1]), .level(lvl[1]), .frame_err(ferr[1]), .overflow(ovf[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clks_of(input int s);
    return (s == 0) ? 1 : 4;
  endfunction

  function automatic int exp_size(input int s);
    return (s == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic void exp_clear();
    exp0.delete();
    exp1.delete();
    ovf_m[0] = 1'b0;
    ovf_m[1] = 1'b0;
  endfunction

  // Reference: a good byte is queued unless the FIFO already holds Depth bytes and
  // no pop coincides with the push.
  function automatic void model_push(input int s, input logic [7:0] b, input logic pop_same);
    if (exp_size(s) < Depth || pop_same) begin
      if (s == 0) exp0.push_back(b);
      else exp1.push_back(b);
    end else begin
      ovf_m[s] = 1'b1;
    end
  endfunction

  // Every pop is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (dv[0] && dr[0]) begin
        check("pop_c1_expected", 32'(exp0.size() != 0), 32'd1);
        if (exp0.size() != 0) check("pop_c1_data", 32'(dout[0]), 32'(exp0.pop_front()));
      end
      if (dv[1] && dr[1]) begin
        check("pop_c4_expected", 32'(exp1.size() != 0), 32'd1);
        if (exp1.size() != 0) check("pop_c4_data", 32'(dout[1]), 32'(exp1.pop_front()));
      end
      if (ferr[0]) ferr_cnt[0]++;
      if (ferr[1]) ferr_cnt[1]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int s, input int n);
    rx[s] = 1'b1;
    tick(n);
  endtask

  // Drives start, 8 data bits LSB first, and the stop bit; the line is left at the stop level.
  // pop_at_stop raises data_ready for exactly the stop-sample cycle.
  task automatic send_frame(input int s, input logic [7:0] data, input logic stop,
                            input logic pop_at_stop, input logic rnd_ready);
    int c = clks_of(s);
    int stop_cyc = 2 + (c - 1) / 2 + 9 * c;
    int len = pop_at_stop ? stop_cyc + 1 : 10 * c;
    logic [9:0] fr = {stop, data, 1'b0};
    if (stop) model_push(s, data, pop_at_stop);
    for (int t = 0; t < len; t++) begin
      rx[s] = (t < 10 * c) ? fr[t / c] : stop;
      if (pop_at_stop) dr[s] = (t == stop_cyc);
      else if (rnd_ready) dr[s] = 1'($urandom_range(0, 1));
      tick(1);
    end
    if (pop_at_stop) dr[s] = 1'b0;
  endtask

  task automatic drain(input int s);
    dr[s] = 1'b1;
    for (int i = 0; i < 40 && dv[s]; i++) tick(1);
    dr[s] = 1'b0;
    tick(1);
    check("drain_level", 32'(lvl[s]), 32'd0);
    check("drain_model_empty", 32'(exp_size(s)), 32'd0);
  endtask

  task automatic reset_all();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_clear();
    tick(2);
  endtask

  initial begin
    string line;
    logic [9:0] fr;
    int base, nerr, n, gap;
    logic err;
    logic [7:0] b;

    rx[0] = 1'b1; rx[1] = 1'b1; dr[0] = 1'b0; dr[1] = 1'b0;
    ferr_cnt[0] = 0; ferr_cnt[1] = 0;
    exp_clear();
    #2 reset = 1'b1;
    tick(2);
    for (int s = 0; s < 2; s++) begin
      check("rst_data_out", 32'(dout[s]), 32'h00);
      check("rst_valid", 32'(dv[s]), 32'd0);
      check("rst_level", 32'(lvl[s]), 32'd0);
      check("rst_frame_err", 32'(ferr[s]), 32'd0);
      check("rst_overflow", 32'(ovf[s]), 32'd0);
    end
    reset = 1'b0;
    tick(3);

    // Single "T" frame at one clock per bit.
    send_frame(0, 8'h54, 1'b1, 1'b0, 1'b0);
    idle(0, 6);
    check("t_level", 32'(lvl[0]), 32'(exp_size(0)));
    check("t_valid", 32'(dv[0]), 32'd1);
    check("t_data", 32'(dout[0]), 32'h54);
    drain(0);

    // A full text line, back-to-back 11-cycle frames, consumer always ready.
    line = "The quick brown fox jumps over the lazy dog!";
    dr[0] = 1'b1;
    base = ferr_cnt[0];
    for (int i = 0; i < line.len(); i++) begin
      send_frame(0, line[i], 1'b1, 1'b0, 1'b0);
      idle(0, 1);
    end
    send_frame(0, 8'h0D, 1'b1, 1'b0, 1'b0);
    idle(0, 1);
    send_frame(0, 8'h0A, 1'b1, 1'b0, 1'b0);
    idle(0, 6);
    drain(0);
    check("line_frame_err", 32'(ferr_cnt[0] - base), 32'd0);
    check("line_overflow", 32'(ovf[0]), 32'd0);

    // One-cycle glitch at four clocks per bit, then a real 'A'.
    base = ferr_cnt[1];
    rx[1] = 1'b0;
    tick(1);
    idle(1, 20);
    check("glitch_level", 32'(lvl[1]), 32'd0);
    check("glitch_frame_err", 32'(ferr_cnt[1] - base), 32'd0);
    send_frame(1, 8'h41, 1'b1, 1'b0, 1'b0);
    idle(1, 8);
    check("glitch_next_data", 32'(dout[1]), 32'h41);
    check("glitch_next_level", 32'(lvl[1]), 32'd1);
    drain(1);

    // Low stop bit, line then held low: one error pulse and no new frame.
    base = ferr_cnt[1];
    send_frame(1, 8'h55, 1'b0, 1'b0, 1'b0);
    tick(48);
    check("ferr_pulses", 32'(ferr_cnt[1] - base), 32'd1);
    check("ferr_level", 32'(lvl[1]), 32'd0);
    idle(1, 8);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(1, 8);
    check("ferr_next_data", 32'(dout[1]), 32'h3C);
    check("ferr_next_pulses", 32'(ferr_cnt[1] - base), 32'd1);
    drain(1);

    // Five bytes into four entries with nobody consuming.
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 1'b1, 1'b0, 1'b0);
      idle(0, 1);
    end
    idle(0, 6);
    check("ovf_level", 32'(lvl[0]), 32'(exp_size(0)));
    check("ovf_flag", 32'(ovf[0]), 32'(ovf_m[0]));
    check("ovf_head", 32'(dout[0]), 32'h01);
    drain(0);
    check("ovf_sticky", 32'(ovf[0]), 32'(ovf_m[0]));

    // Same again, but the head leaves in the fifth byte's push cycle.
    reset_all();
    for (int i = 1; i <= 4; i++) begin
      send_frame(0, 8'(i), 1'b1, 1'b0, 1'b0);
      idle(0, 1);
    end
    send_frame(0, 8'h05, 1'b1, 1'b1, 1'b0);
    idle(0, 6);
    check("popfull_level", 32'(lvl[0]), 32'(exp_size(0)));
    check("popfull_overflow", 32'(ovf[0]), 32'(ovf_m[0]));
    check("popfull_head", 32'(dout[0]), 32'h02);
    drain(0);

    // Asynchronous reset in the middle of a data bit.
    send_frame(1, 8'h77, 1'b1, 1'b0, 1'b0);
    idle(1, 8);
    check("pre_reset_level", 32'(lvl[1]), 32'd1);
    fr = {1'b1, 8'hC3, 1'b0};
    for (int t = 0; t < 14; t++) begin
      rx[1] = fr[t / 4];
      tick(1);
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_data_out", 32'(dout[1]), 32'h00);
    check("midrst_valid", 32'(dv[1]), 32'd0);
    check("midrst_level", 32'(lvl[1]), 32'd0);
    check("midrst_frame_err", 32'(ferr[1]), 32'd0);
    check("midrst_overflow", 32'(ovf[1]), 32'd0);
    exp_clear();
    rx[1] = 1'b1;
    tick(2);
    reset = 1'b0;
    base = ferr_cnt[1];
    tick(3);
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(1, 8);
    check("postrst_data", 32'(dout[1]), 32'hA5);
    check("postrst_level", 32'(lvl[1]), 32'd1);
    check("postrst_frame_err", 32'(ferr_cnt[1] - base), 32'd0);
    drain(1);

    // Random bytes, random gaps, occasional bad stop bits, random consumer.
    for (int s = 0; s < 2; s++) begin
      base = ferr_cnt[s];
      nerr = 0;
      n = $urandom_range(16, 24);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        err = ($urandom_range(0, 7) == 0);
        if (err) nerr++;
        send_frame(s, b, !err, 1'b0, 1'b1);
        gap = $urandom_range(err ? 1 : 0, 2 * clks_of(s));
        idle(s, gap);
      end
      idle(s, 6 * clks_of(s));
      drain(s);
      check("rand_frame_err", 32'(ferr_cnt[s] - base), 32'(nerr));
      check("rand_overflow", 32'(ovf[s]), 32'(ovf_m[s]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
